ysyx_23060171_pc_seq: RTL and testbench
=======================================

// Module: ysyx_23060171_pc_seq
// PURPOSE
//  Owns the architectural PC and sequences the multi-cycle fetch/execute loop.
//  Issues fetch requests to the IFU and waits for the instruction.
//  Waits for the WBU commit, whose PCSrc (snpc/dnpc/dnpc_r/trap) selects the next PC.
//  Runs a watchdog on fetch latency.
// PARAMETERS
//  XLEN      32            data/address width
//  RESET_PC  32'h8000_0000 PC loaded on reset
//  TMO_W     8             watchdog counter width; timeout at 2**TMO_W-1 wait cycles
// PORTS
//  clock        in   1     system clock
//  reset        in   1     asynchronous active-high reset
//  fetch_valid  out  1     fetch request valid; address is pc
//  fetch_ready  in   1     IFU accepts request
//  pc           out  XLEN  current architectural PC
//  inst_valid   in   1     IFU returns instruction (1-cycle pulse)
//  exec_busy    out  1     instruction in flight between IFU return and commit
//  commit_valid in   1     WBU commit (1-cycle pulse)
//  pcsrc        in   2     00 snpc, 01 dnpc, 10 dnpc_r, 11 trap
//  dnpc_tgt     in   XLEN  branch/jal target (pc+imm)
//  jalr_tgt     in   XLEN  rs1+imm, unmasked
//  trap_tgt     in   XLEN  mtvec/mepc from CSR unit
//  fetch_tmo    out  1     sticky: fetch watchdog expired
//  misalign     out  1     1-cycle pulse: misaligned target (only with macro)
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=FETCH, fetch_valid=0 for the first cycle after reset release, then 1.
//  Reset: exec_busy=0, fetch_tmo=0, misalign=0, watchdog=0. Reset mid-operation aborts the instruction.
//  FSM states: FETCH, WAIT_I, EXEC, HALT.
//  FETCH: fetch_valid=1. fetch_valid=1 && fetch_ready=1 -> WAIT_I.
//  FETCH: pc and fetch_valid are held stable while ready=0.
//  WAIT_I: inst_valid=1 -> EXEC, and exec_busy rises next cycle.
//  WAIT_I: if inst_valid arrives in the same cycle as the handshake, it is ignored. The IFU must return it later.
//  EXEC: exec_busy=1. commit_valid=1 -> next-pc computed and latched. Then -> FETCH, fetch_valid=1 next cycle.
//  Next-pc: 00 pc+4 (mod 2**XLEN, wraps to 0), 01 dnpc_tgt, 10 {jalr_tgt[XLEN-1:1],1'b0}, 11 trap_tgt.
//  Latency: minimum 3 cycles per instruction (FETCH, WAIT_I, EXEC) when ready/valid/commit arrive immediately.
//  Watchdog: counts every cycle in FETCH or WAIT_I, and clears on state entry to EXEC.
//  Watchdog: at 2**TMO_W-1 it sets fetch_tmo and goes to HALT.
//  HALT: fetch_valid=0, pc frozen. Left only via reset.
//  Spurious pulses: commit_valid outside EXEC and inst_valid outside WAIT_I are ignored.
//  Simultaneous inst_valid and commit_valid in WAIT_I: only inst_valid is taken.
// CONFIGURATION
//  PC_SEQ_ALIGN_CHECK_EN defined:
//   - A selected target with bit[1]=1 (after the jalr mask) is misaligned.
//   - Then misalign pulses for 1 cycle and pc <- trap_tgt.
//   - pcsrc=11 is never checked.
//  Undefined: no check, misalign tied 0, target used as is.
// TESTING
//  T1 reset release: fetch_valid=1 one cycle after release, pc=0x8000_0000.
//  T1 ready=1, inst_valid next cycle, commit pcsrc=00 -> pc=0x8000_0004 after 3 cycles.
//  T2 pc=0x8000_0010, pcsrc=01, dnpc_tgt=0x8000_0100 -> pc=0x8000_0100.
//  T2 pcsrc=10, jalr_tgt=0x8000_0203 -> pc=0x8000_0202.
//  T3 pc=0xFFFF_FFFC, pcsrc=00 -> pc=0x0000_0000.
//  T3 fetch_ready=0 for 5 cycles: pc and fetch_valid stable throughout.
//  T4 inst_valid never returns -> fetch_tmo=1 after 255 wait cycles; fetch_valid=0 until reset.
//  T4 assert reset -> fetch_tmo=0.
//  T5 commit_valid pulsed in WAIT_I, then inst_valid+commit pcsrc=11, trap_tgt=0x8000_1000.
//  T5 required: the early commit is ignored and pc=0x8000_1000.
//  T6 (PC_SEQ_ALIGN_CHECK_EN) pcsrc=01, dnpc_tgt=0x8000_0102, trap_tgt=0x8000_2000.
//  T6 required: misalign 1-cycle pulse and pc=0x8000_2000. Macro undefined: pc=0x8000_0102.
//  Reset mid-EXEC: pc=RESET_PC and exec_busy=0 immediately.

Source files
------------

// File: rtl/ysyx_23060171_pc_seq.sv
// ---------------------------------------------------------------------------
// ysyx_23060171_pc_seq
// Owns the architectural PC and steps the multi-cycle FETCH -> WAIT_I -> EXEC
// loop. It issues a fetch request, waits for the IFU to return the
// instruction, then waits for the WBU commit, whose pcsrc selects the next PC.
// A watchdog on fetch latency halts the sequencer if the IFU stops answering.
//
// Optional feature: define PC_SEQ_ALIGN_CHECK_EN to redirect misaligned
// targets (bit[1] set) to trap_tgt and pulse the misalign output.
// ---------------------------------------------------------------------------
module ysyx_23060171_pc_seq #(
   parameter int unsigned          XLEN     = 32,
   parameter logic [XLEN-1:0]      RESET_PC = 32'h8000_0000,
   parameter int unsigned          TMO_W    = 8
) (
   input  logic            clock,
   input  logic            reset,
   output logic            fetch_valid,
   input  logic            fetch_ready,
   output logic [XLEN-1:0] pc,
   input  logic            inst_valid,
   output logic            exec_busy,
   input  logic            commit_valid,
   input  logic [1:0]      pcsrc,
   input  logic [XLEN-1:0] dnpc_tgt,
   input  logic [XLEN-1:0] jalr_tgt,
   input  logic [XLEN-1:0] trap_tgt,
   output logic            fetch_tmo,
   output logic            misalign
);

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_WAIT_I = 2'd1,
      S_EXEC   = 2'd2,
      S_HALT   = 2'd3
   } state_e;

   localparam logic [1:0] PCSRC_SNPC   = 2'b00;
   localparam logic [1:0] PCSRC_DNPC   = 2'b01;
   localparam logic [1:0] PCSRC_DNPC_R = 2'b10;
   localparam logic [1:0] PCSRC_TRAP   = 2'b11;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [TMO_W-1:0]  wdog_q, wdog_d;
   logic              tmo_q, tmo_d;
   // Low for the first cycle after reset release so fetch_valid starts late.
   logic              started_q, started_d;
`ifdef PC_SEQ_ALIGN_CHECK_EN
   logic              misalign_q, misalign_d;
   logic              tgt_bad;
`endif

   logic [XLEN-1:0]   sel_tgt;
   logic [XLEN-1:0]   next_pc;
   logic [TMO_W-1:0]  wdog_inc;
   logic              tmo_hit;
   logic              fetch_fire;
   logic              take_commit;

   assign fetch_fire  = started_q && (state_q == S_FETCH) && fetch_ready;
   assign take_commit = (state_q == S_EXEC) && commit_valid;
   assign wdog_inc    = wdog_q + TMO_W'(1);
   assign tmo_hit     = (wdog_inc == {TMO_W{1'b1}});

   // Next-PC selection from the commit's pcsrc, with optional alignment redirect.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can
      // leave it unassigned and infer a latch.
      sel_tgt = pc_q + XLEN'(4);
      unique case (pcsrc)
         PCSRC_SNPC:   sel_tgt = pc_q + XLEN'(4);
         PCSRC_DNPC:   sel_tgt = dnpc_tgt;
         PCSRC_DNPC_R: sel_tgt = {jalr_tgt[XLEN-1:1], 1'b0};
         PCSRC_TRAP:   sel_tgt = trap_tgt;
         default:      sel_tgt = pc_q + XLEN'(4);
      endcase
`ifdef PC_SEQ_ALIGN_CHECK_EN
      // Trap vectors come from the CSR unit and are trusted as is.
      tgt_bad = (pcsrc != PCSRC_TRAP) && sel_tgt[1];
      next_pc = tgt_bad ? trap_tgt : sel_tgt;
`else
      next_pc = sel_tgt;
`endif
   end

   // Next-state logic of the fetch/execute FSM.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_FETCH: begin
            if (tmo_hit)         state_d = S_HALT;
            else if (fetch_fire) state_d = S_WAIT_I;
         end
         S_WAIT_I: begin
            // inst_valid wins over both a late timeout and a stray commit.
            if (inst_valid)      state_d = S_EXEC;
            else if (tmo_hit)    state_d = S_HALT;
         end
         S_EXEC: begin
            if (commit_valid)    state_d = S_FETCH;
         end
         S_HALT:                 state_d = S_HALT;
         default:                state_d = S_FETCH;
      endcase
   end

   // Datapath next values: PC, watchdog, sticky timeout, start flag, misalign.
   always_comb begin
      started_d = 1'b1;
      pc_d      = take_commit ? next_pc : pc_q;
      tmo_d     = tmo_q || (state_d == S_HALT);
      wdog_d    = wdog_q;
      if (state_d == S_EXEC)
         wdog_d = '0;
      else if ((state_q == S_FETCH) || (state_q == S_WAIT_I))
         wdog_d = wdog_inc;
`ifdef PC_SEQ_ALIGN_CHECK_EN
      misalign_d = take_commit && tgt_bad;
`endif
   end

   // State and datapath registers; reset aborts any instruction in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_FETCH;
         pc_q       <= RESET_PC;
         wdog_q     <= '0;
         tmo_q      <= 1'b0;
         started_q  <= 1'b0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples its _d value from before the edge, independent of order.
         state_q    <= state_d;
         pc_q       <= pc_d;
         wdog_q     <= wdog_d;
         tmo_q      <= tmo_d;
         started_q  <= started_d;
`ifdef PC_SEQ_ALIGN_CHECK_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   // Moore outputs decoded from the current state and registers.
   always_comb begin
      fetch_valid = started_q && (state_q == S_FETCH);
      exec_busy   = (state_q == S_EXEC);
      pc          = pc_q;
      fetch_tmo   = tmo_q;
`ifdef PC_SEQ_ALIGN_CHECK_EN
      misalign    = misalign_q;
`else
      misalign    = 1'b0;
`endif
   end

endmodule

// File: tb/tb_ysyx_23060171_pc_seq.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060171_pc_seq
// Directed self-checking bench for the PC sequencer. Inputs change 1 time
// unit after the rising edge; outputs are sampled at the same point.
// Honours PC_SEQ_ALIGN_CHECK_EN for the misaligned-target expectations.
// ---------------------------------------------------------------------------
module tb_ysyx_23060171_pc_seq;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clock = 1'b0;
   logic        reset;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] pc;
   logic        inst_valid;
   logic        exec_busy;
   logic        commit_valid;
   logic [1:0]  pcsrc;
   logic [31:0] dnpc_tgt;
   logic [31:0] jalr_tgt;
   logic [31:0] trap_tgt;
   logic        fetch_tmo;
   logic        misalign;

   int checks = 0;
   int errors = 0;

   ysyx_23060171_pc_seq #(
      .XLEN     (32),
      .RESET_PC (RESET_PC),
      .TMO_W    (8)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .fetch_valid  (fetch_valid),
      .fetch_ready  (fetch_ready),
      .pc           (pc),
      .inst_valid   (inst_valid),
      .exec_busy    (exec_busy),
      .commit_valid (commit_valid),
      .pcsrc        (pcsrc),
      .dnpc_tgt     (dnpc_tgt),
      .jalr_tgt     (jalr_tgt),
      .trap_tgt     (trap_tgt),
      .fetch_tmo    (fetch_tmo),
      .misalign     (misalign)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // One full instruction from FETCH with immediate ready/valid/commit.
   task automatic do_instr(input logic [1:0] src, input logic [31:0] d,
                           input logic [31:0] j, input logic [31:0] t);
      fetch_ready = 1'b1;
      step();
      fetch_ready = 1'b0;
      inst_valid  = 1'b1;
      step();
      inst_valid   = 1'b0;
      pcsrc        = src;
      dnpc_tgt     = d;
      jalr_tgt     = j;
      trap_tgt     = t;
      commit_valid = 1'b1;
      step();
      commit_valid = 1'b0;
   endtask

   initial begin
      int          n;
      logic [31:0] exp_pc;
      logic        exp_mis;

      reset        = 1'b1;
      fetch_ready  = 1'b0;
      inst_valid   = 1'b0;
      commit_valid = 1'b0;
      pcsrc        = 2'b00;
      dnpc_tgt     = '0;
      jalr_tgt     = '0;
      trap_tgt     = '0;
      step();
      step();
      check("rst_pc", pc, RESET_PC);
      check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
      check("rst_exec_busy", {31'd0, exec_busy}, 32'd0);
      check("rst_fetch_tmo", {31'd0, fetch_tmo}, 32'd0);
      check("rst_misalign", {31'd0, misalign}, 32'd0);

      // T1: release, fetch_valid one cycle later, then a sequential instruction.
      reset = 1'b0;
      #1;
      check("t1_first_cycle_fv", {31'd0, fetch_valid}, 32'd0);
      step();
      check("t1_fv_up", {31'd0, fetch_valid}, 32'd1);
      check("t1_pc", pc, 32'h8000_0000);
      fetch_ready = 1'b1;
      step();
      fetch_ready = 1'b0;
      check("t1_wait_fv", {31'd0, fetch_valid}, 32'd0);
      check("t1_wait_busy", {31'd0, exec_busy}, 32'd0);
      inst_valid = 1'b1;
      step();
      inst_valid = 1'b0;
      check("t1_exec_busy", {31'd0, exec_busy}, 32'd1);
      check("t1_exec_pc", pc, 32'h8000_0000);
      commit_valid = 1'b1;
      pcsrc        = 2'b00;
      step();
      commit_valid = 1'b0;
      check("t1_pc_next", pc, 32'h8000_0004);
      check("t1_busy_low", {31'd0, exec_busy}, 32'd0);
      check("t1_fv_again", {31'd0, fetch_valid}, 32'd1);

      // T2: dnpc and masked jalr targets.
      do_instr(2'b01, 32'h8000_0010, '0, '0);
      check("t2_set_pc", pc, 32'h8000_0010);
      do_instr(2'b01, 32'h8000_0100, '0, '0);
      check("t2_dnpc", pc, 32'h8000_0100);
      do_instr(2'b10, '0, 32'h8000_0203, 32'h8000_3000);
`ifdef PC_SEQ_ALIGN_CHECK_EN
      exp_pc  = 32'h8000_3000;
      exp_mis = 1'b1;
`else
      exp_pc  = 32'h8000_0202;
      exp_mis = 1'b0;
`endif
      check("t2_jalr", pc, exp_pc);
      check("t2_jalr_misalign", {31'd0, misalign}, {31'd0, exp_mis});

      // T3: pc+4 wraps, then a 5-cycle ready stall with stray pulses.
      do_instr(2'b01, 32'hFFFF_FFFC, '0, '0);
      check("t3_set_pc", pc, 32'hFFFF_FFFC);
      do_instr(2'b00, '0, '0, '0);
      check("t3_wrap", pc, 32'h0000_0000);
      for (int i = 0; i < 5; i++) begin
         commit_valid = (i == 1);
         inst_valid   = (i == 2);
         pcsrc        = 2'b01;
         dnpc_tgt     = 32'h1234_5678;
         step();
         check("t3_stall_pc", pc, 32'h0000_0000);
         check("t3_stall_fv", {31'd0, fetch_valid}, 32'd1);
         check("t3_stall_busy", {31'd0, exec_busy}, 32'd0);
      end
      commit_valid = 1'b0;
      inst_valid   = 1'b0;

      // T5: inst_valid on the handshake cycle and early commit are ignored.
      fetch_ready = 1'b1;
      inst_valid  = 1'b1;
      step();
      fetch_ready = 1'b0;
      inst_valid  = 1'b0;
      check("t5_hs_inst_ignored", {31'd0, exec_busy}, 32'd0);
      step();
      check("t5_still_wait", {31'd0, exec_busy}, 32'd0);
      check("t5_wait_fv", {31'd0, fetch_valid}, 32'd0);
      commit_valid = 1'b1;
      pcsrc        = 2'b01;
      dnpc_tgt     = 32'h8000_0400;
      step();
      commit_valid = 1'b0;
      check("t5_early_commit_pc", pc, 32'h0000_0000);
      check("t5_early_commit_busy", {31'd0, exec_busy}, 32'd0);
      inst_valid   = 1'b1;
      commit_valid = 1'b1;
      pcsrc        = 2'b11;
      trap_tgt     = 32'h8000_1000;
      step();
      inst_valid   = 1'b0;
      commit_valid = 1'b0;
      check("t5_both_busy", {31'd0, exec_busy}, 32'd1);
      check("t5_both_pc", pc, 32'h0000_0000);
      commit_valid = 1'b1;
      step();
      commit_valid = 1'b0;
      check("t5_trap_pc", pc, 32'h8000_1000);

      // T6: dnpc target with bit[1] set.
      do_instr(2'b01, 32'h8000_0102, '0, 32'h8000_2000);
`ifdef PC_SEQ_ALIGN_CHECK_EN
      exp_pc  = 32'h8000_2000;
      exp_mis = 1'b1;
`else
      exp_pc  = 32'h8000_0102;
      exp_mis = 1'b0;
`endif
      check("t6_pc", pc, exp_pc);
      check("t6_misalign", {31'd0, misalign}, {31'd0, exp_mis});
      step();
      check("t6_misalign_pulse", {31'd0, misalign}, 32'd0);

      // Reset in the middle of EXEC takes effect without a clock edge.
      fetch_ready = 1'b1;
      step();
      fetch_ready = 1'b0;
      inst_valid  = 1'b1;
      step();
      inst_valid = 1'b0;
      check("rexec_busy_before", {31'd0, exec_busy}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("rexec_pc", pc, RESET_PC);
      check("rexec_busy", {31'd0, exec_busy}, 32'd0);
      step();
      reset = 1'b0;
      step();
      check("rexec_fv", {31'd0, fetch_valid}, 32'd1);
      do_instr(2'b00, '0, '0, '0);
      check("rexec_pc_next", pc, 32'h8000_0004);

      // T4: the IFU never answers; 1 FETCH cycle + 254 WAIT_I cycles = 255.
      fetch_ready = 1'b1;
      step();
      fetch_ready = 1'b0;
      n = 0;
      while (!fetch_tmo && n < 400) begin
         step();
         n++;
      end
      check("t4_tmo_cycles", n, 254);
      check("t4_tmo", {31'd0, fetch_tmo}, 32'd1);
      check("t4_halt_fv", {31'd0, fetch_valid}, 32'd0);
      fetch_ready  = 1'b1;
      inst_valid   = 1'b1;
      commit_valid = 1'b1;
      step();
      inst_valid   = 1'b0;
      commit_valid = 1'b0;
      step();
      step();
      fetch_ready = 1'b0;
      check("t4_halt_pc", pc, 32'h8000_0004);
      check("t4_halt_fv_held", {31'd0, fetch_valid}, 32'd0);
      check("t4_halt_busy", {31'd0, exec_busy}, 32'd0);
      check("t4_tmo_sticky", {31'd0, fetch_tmo}, 32'd1);
      reset = 1'b1;
      #1;
      check("t4_rst_tmo", {31'd0, fetch_tmo}, 32'd0);
      check("t4_rst_pc", pc, RESET_PC);
      step();
      reset = 1'b0;
      step();
      check("t4_rst_fv", {31'd0, fetch_valid}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
